// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction in flight.
// Define MEM_PORT_ARBITER_RR_EN for round-robin arbitration instead of LSU priority with starvation guard.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned MAX_WAIT   = 4,
    localparam int unsigned MASK_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0] ifu_addr,
    output logic                  ifu_resp_valid,
    output logic [DATA_WIDTH-1:0] ifu_rdata,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic                  lsu_wen,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    input  logic [MASK_WIDTH-1:0] lsu_wmask,
    output logic                  lsu_resp_valid,
    output logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wen,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [MASK_WIDTH-1:0] mem_wmask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t state;
    logic   ownerLsu;
    logic   isIdle;
    logic   forceIfu;
    logic   grantLsu;
    logic   grantIfu;
    logic   respFire;

    // forceIfu: IFU takes a tie this cycle
`ifdef MEM_PORT_ARBITER_RR_EN
    logic lastLsu;

    assign forceIfu = lastLsu;

    always_ff @(posedge clk) begin
        if (rst) begin
            lastLsu <= 1'b0;
        end else if (grantLsu) begin
            lastLsu <= 1'b1;
        end else if (grantIfu) begin
            lastLsu <= 1'b0;
        end
    end
`else
    localparam int unsigned CNT_WIDTH = 4;

    logic [CNT_WIDTH-1:0] waitCnt;

    assign forceIfu = (waitCnt == CNT_WIDTH'(MAX_WAIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            waitCnt <= '0;
        end else if (state == IDLE) begin
            if (grantIfu || !ifu_req_valid) begin
                waitCnt <= '0;
            end else if (grantLsu && !forceIfu) begin
                waitCnt <= waitCnt + CNT_WIDTH'(1);
            end
        end
    end
`endif

    assign isIdle   = (state == IDLE) && !rst;
    assign grantLsu = isIdle && lsu_req_valid && !(ifu_req_valid && forceIfu);
    assign grantIfu = isIdle && ifu_req_valid && !grantLsu;
    assign respFire = (state == RESP) && mem_resp_valid && !rst;

    assign ifu_req_ready  = grantIfu;
    assign lsu_req_ready  = grantLsu;
    assign ifu_resp_valid = respFire && !ownerLsu;
    assign lsu_resp_valid = respFire && ownerLsu;
    assign ifu_rdata      = ifu_resp_valid ? mem_rdata : '0;
    assign lsu_rdata      = lsu_resp_valid ? mem_rdata : '0;
    assign mem_req_valid  = (state == REQ);
    assign busy           = (state != IDLE);

    // Transaction sequencer and latched request fields
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ownerLsu  <= 1'b0;
            mem_addr  <= '0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grantIfu) begin
                        ownerLsu  <= 1'b0;
                        mem_addr  <= ifu_addr;
                        mem_wen   <= 1'b0;
                        mem_wdata <= '0;
                        mem_wmask <= '0;
                        state     <= REQ;
                    end else if (grantLsu) begin
                        ownerLsu  <= 1'b1;
                        mem_addr  <= lsu_addr;
                        mem_wen   <= lsu_wen;
                        mem_wdata <= lsu_wdata;
                        mem_wmask <= lsu_wmask;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (mem_resp_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter; expected responses queued at grant, checked at response.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [AW-1:0] ifu_addr;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata, lsu_rdata;
    logic [7:0]    lsu_wmask;
    logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [7:0]    mem_wmask;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic          isLsu;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one transaction from the IDLE grant cycle; requester inputs must already be driven.
    task automatic runTxn(input bit expLsu, input logic [AW-1:0] expAddr, input bit expWen,
                          input logic [DW-1:0] expWdata, input logic [7:0] expMask,
                          input logic [DW-1:0] rdata, input int stall, input bit spurious,
                          input bit pokeIfu);
        exp_t e;
        #1;
        chk1("grant_ifu_ready", ifu_req_ready, !expLsu);
        chk1("grant_lsu_ready", lsu_req_ready, expLsu);
        sb.push_back('{isLsu: expLsu, data: rdata});
        tick();
        if (expLsu) lsu_req_valid = 1'b0;
        else ifu_req_valid = 1'b0;
        if (pokeIfu) ifu_req_valid = 1'b1;
        for (int s = 0; s < stall; s++) begin
            mem_req_ready  = 1'b0;
            mem_resp_valid = spurious;
            mem_rdata      = 64'hBAD0_BAD0_BAD0_BAD0;
            #1;
            chk1("stall_req_valid", mem_req_valid, 1'b1);
            chk("stall_addr", mem_addr, expAddr);
            chk1("stall_wen", mem_wen, expWen);
            chk("stall_wdata", mem_wdata, expWdata);
            chk("stall_wmask", 64'(mem_wmask), 64'(expMask));
            chk1("stall_ifu_ready", ifu_req_ready, 1'b0);
            chk1("stall_ifu_resp", ifu_resp_valid, 1'b0);
            chk1("stall_lsu_resp", lsu_resp_valid, 1'b0);
            tick();
        end
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        #1;
        chk1("req_valid", mem_req_valid, 1'b1);
        chk("req_addr", mem_addr, expAddr);
        chk1("req_wen", mem_wen, expWen);
        chk("req_wdata", mem_wdata, expWdata);
        chk("req_wmask", 64'(mem_wmask), 64'(expMask));
        chk1("req_busy", busy, 1'b1);
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = rdata;
        #1;
        chk1("resp_req_valid", mem_req_valid, 1'b0);
        chk1("resp_ifu_ready", ifu_req_ready, 1'b0);
        chk1("resp_lsu_ready", lsu_req_ready, 1'b0);
        if (sb.size() == 0) begin
            chk1("scoreboard_empty", 1'b1, 1'b0);
        end else begin
            e = sb.pop_front();
            chk1("resp_ifu_valid", ifu_resp_valid, !e.isLsu);
            chk1("resp_lsu_valid", lsu_resp_valid, e.isLsu);
            chk("resp_ifu_rdata", ifu_rdata, e.isLsu ? 64'h0 : e.data);
            chk("resp_lsu_rdata", lsu_rdata, e.isLsu ? e.data : 64'h0);
        end
        tick();
        mem_resp_valid = 1'b0;
        if (pokeIfu) ifu_req_valid = 1'b0;
        #1;
        chk1("post_busy", busy, 1'b0);
    endtask

    initial begin
        bit lsuWins;
        rst = 1'b1;
        ifu_req_valid = 1'b0; ifu_addr = '0;
        lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
        tick();
        tick();
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk1("rst_ifu_ready", ifu_req_ready, 1'b0);
        chk1("rst_lsu_ready", lsu_req_ready, 1'b0);
        chk1("rst_ifu_resp", ifu_resp_valid, 1'b0);
        chk1("rst_lsu_resp", lsu_resp_valid, 1'b0);
        chk("rst_mem_addr", mem_addr, 64'h0);
        chk("rst_mem_wdata", mem_wdata, 64'h0);
        rst = 1'b0;
        tick();

        // IFU only, single-cycle memory
        ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0000;
        runTxn(1'b0, 64'h8000_0000, 1'b0, 64'h0, 8'h00, 64'h0010_0073, 0, 1'b0, 1'b0);

        // LSU store with three stall cycles, IFU knocking while busy
        lsu_req_valid = 1'b1; lsu_addr = 64'h8000_1000; lsu_wen = 1'b1;
        lsu_wdata = 64'hDEAD_BEEF; lsu_wmask = 8'h0F;
        runTxn(1'b1, 64'h8000_1000, 1'b1, 64'hDEAD_BEEF, 8'h0F, 64'h0, 3, 1'b0, 1'b1);

        // LSU load
        lsu_req_valid = 1'b1; lsu_addr = 64'h8000_2008; lsu_wen = 1'b0;
        lsu_wdata = 64'h1234; lsu_wmask = 8'hFF;
        runTxn(1'b1, 64'h8000_2008, 1'b0, 64'h1234, 8'hFF, 64'hCAFE_F00D_0000_0001, 1, 1'b0, 1'b0);

        // Spurious response in IDLE
        mem_resp_valid = 1'b1; mem_rdata = 64'h5555;
        #1;
        chk1("spur_idle_ifu_resp", ifu_resp_valid, 1'b0);
        chk1("spur_idle_lsu_resp", lsu_resp_valid, 1'b0);
        chk("spur_idle_lsu_rdata", lsu_rdata, 64'h0);
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk1("spur_idle_busy", busy, 1'b0);
        chk1("spur_idle_req_valid", mem_req_valid, 1'b0);

        // Spurious responses while in REQ
        ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0004;
        runTxn(1'b0, 64'h8000_0004, 1'b0, 64'h0, 8'h00, 64'h0000_0013, 2, 1'b1, 1'b0);

        // Reset while waiting in RESP
        ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0008;
        #1;
        chk1("rr_grant", ifu_req_ready, 1'b1);
        tick();
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        #1;
        chk1("rr_in_resp_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk1("rr_busy", busy, 1'b0);
        chk1("rr_req_valid", mem_req_valid, 1'b0);
        chk("rr_mem_addr", mem_addr, 64'h0);
        mem_resp_valid = 1'b1; mem_rdata = 64'h7777;
        #1;
        chk1("rr_late_ifu_resp", ifu_resp_valid, 1'b0);
        chk("rr_late_ifu_rdata", ifu_rdata, 64'h0);
        tick();
        mem_resp_valid = 1'b0;
        ifu_req_valid = 1'b1; ifu_addr = 64'h8000_000C;
        runTxn(1'b0, 64'h8000_000C, 1'b0, 64'h0, 8'h00, 64'h0000_0067, 0, 1'b0, 1'b0);

        // Contention: both requesters valid on every IDLE cycle
        tick();
        ifu_addr = 64'h8000_0100;
        lsu_addr = 64'h8000_3000; lsu_wen = 1'b0; lsu_wdata = 64'h0; lsu_wmask = 8'h00;
        for (int i = 0; i < 10; i++) begin
`ifdef MEM_PORT_ARBITER_RR_EN
            lsuWins = (i % 2) == 0;
`else
            lsuWins = (i % 5) != 4;
`endif
            ifu_req_valid = 1'b1;
            lsu_req_valid = 1'b1;
            runTxn(lsuWins, lsuWins ? 64'h8000_3000 : 64'h8000_0100, 1'b0, 64'h0, 8'h00,
                   64'h1000 + 64'(i), 0, 1'b0, 1'b0);
        end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        tick();
        chk("sb_drained", 64'(sb.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port between instruction fetch (IFU, read-only) and load/store (LSU, read/write).
- Sits between the fetch/LSU logic and the memory model, so the core can move from ideal combinational memory to one multi-cycle shared port.
- One transaction in flight at a time. Request/response use valid/ready on the requester side and valid/ready plus resp_valid on the memory side.

Parameters:
- ADDR_WIDTH, 64, address width of all ports
- DATA_WIDTH, 64, read/write data width
- MAX_WAIT, 4, consecutive LSU wins while IFU waits before IFU is forced to win (range 1..15)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_WIDTH  fetch address
- ifu_resp_valid  out  1  IFU response strobe
- ifu_rdata  out  DATA_WIDTH  fetched data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  ADDR_WIDTH  load/store address
- lsu_wen  in  1  1 = store
- lsu_wdata  in  DATA_WIDTH  store data
- lsu_wmask  in  8  store byte mask
- lsu_resp_valid  out  1  LSU response strobe (load data or store ack)
- lsu_rdata  out  DATA_WIDTH  load data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  ADDR_WIDTH  latched address
- mem_wen  out  1  latched write enable
- mem_wdata  out  DATA_WIDTH  latched write data
- mem_wmask  out  8  latched mask
- mem_resp_valid  in  1  memory response
- mem_rdata  in  DATA_WIDTH  memory read data
- busy  out  1  state != IDLE

Behaviour:
- Reset: state = IDLE, owner = IFU, wait_cnt = 0, latched request fields = 0. All *_ready, *_valid and busy are 0.
- Reset mid-transaction discards the in-flight request. A later mem_resp_valid for it is ignored in IDLE.
- FSM states: IDLE, REQ, RESP.
- IDLE, no valid requester: stay in IDLE.
- IDLE, at least one valid requester:
  - pick a winner; assert the winner's req_ready combinationally for that one cycle;
  - latch addr, wen, wdata, wmask and owner; go to REQ;
  - the loser's ready stays 0;
  - IFU requests latch wen = 0, wmask = 0, wdata = 0.
- REQ: mem_req_valid = 1 with the latched fields held stable. When mem_req_ready = 1, go to RESP.
- RESP: when mem_resp_valid = 1:
  - owner's resp_valid = 1 that same cycle (combinational);
  - owner's rdata = mem_rdata;
  - return to IDLE.
- ifu_rdata / lsu_rdata carry mem_rdata whenever their resp_valid is high, and are 0 otherwise.
- mem_resp_valid in IDLE or REQ is ignored.
- Minimum transaction: 3 cycles (accept, request, response), i.e. one new grant every 3 cycles at best.
- Requesters hold valid and fields until ready. A requester may deassert valid before being granted; nothing is latched.
- Arbitration (default): LSU wins when both are valid, except when wait_cnt == MAX_WAIT, in which case IFU wins.
  - wait_cnt increments on each IDLE grant to LSU while ifu_req_valid = 1.
  - wait_cnt clears on any grant to IFU, and on any IDLE cycle with ifu_req_valid = 0.
  - wait_cnt saturates at MAX_WAIT.
- A single valid requester always wins immediately.
- busy = 1 in REQ and RESP.

Optional Feature:
- Macro: MEM_PORT_ARBITER_RR_EN.
- Defined: round-robin arbitration. On a tie, the requester not granted last wins. The last-grant flag resets to IFU, so the first tie goes to LSU. wait_cnt logic is not built.
- Undefined: fixed LSU priority with the MAX_WAIT starvation guard described above.

Test Plan:
- IFU only: ifu_addr=0x80000000; mem_req_ready=1 immediately; mem_resp_valid one cycle after REQ with mem_rdata=0x00100073 -> ifu_req_ready pulses cycle 0, mem_req_valid cycle 1 with mem_addr=0x80000000, mem_wen=0, ifu_resp_valid + ifu_rdata=0x00100073 cycle 2, lsu_resp_valid never 1.
- LSU store: lsu_addr=0x80001000, wdata=0xDEADBEEF, wmask=0x0F, mem_req_ready stalled 3 cycles -> mem fields held stable all 3 stall cycles; lsu_resp_valid only on the mem_resp_valid cycle; ifu_req_ready stays 0 throughout.
- Contention (RR_EN undefined, MAX_WAIT=4): both valid continuously, 1-cycle memory -> grant order L,L,L,L,I,L,L,L,L,I; wait_cnt never exceeds 4.
- Contention (RR_EN defined): both valid continuously -> grant order L,I,L,I,...
- Spurious response: mem_resp_valid=1 in IDLE and during REQ -> no resp_valid asserted, state unchanged.
- Reset in RESP: assert rst for one cycle while waiting on memory -> next cycle state IDLE, busy=0; late mem_resp_valid dropped; next IFU request completes normally.
